// File: rtl/eight_bit_demux_fifo_if.sv
// rtl/eight_bit_demux_fifo_if.sv - sample-bus and per-channel stream bundle for the 2:1 demux FIFO
interface eight_bit_demux_fifo_if #(
  parameter int DEPTH = 4,
  parameter int LVLW  = $clog2(DEPTH) + 1
);
  logic [7:0]      in_data;
  logic            in_sel;
  logic            in_parity;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      out1_data;
  logic            out1_valid;
  logic            out1_ready;
  logic [7:0]      out2_data;
  logic            out2_valid;
  logic            out2_ready;
  logic [LVLW-1:0] ch1_level;
  logic [LVLW-1:0] ch2_level;
  logic [7:0]      err_count;

  modport master (
    output in_data, in_sel, in_parity, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid,
           ch1_level, ch2_level, err_count
  );

  modport slave (
    input  in_data, in_sel, in_parity, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid,
           ch1_level, ch2_level, err_count
  );
endinterface

// File: rtl/eight_bit_demux_fifo.sv
// rtl/eight_bit_demux_fifo.sv - steers tagged beats into two FWFT FIFOs
// Optional even-parity drop/count when EIGHT_BIT_DEMUX_PARITY_EN is defined.
module eight_bit_demux_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  eight_bit_demux_fifo_if.slave bus
);
  localparam int LVLW = $clog2(DEPTH) + 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);

  logic [7:0]      mem_q    [2][DEPTH];
  logic [7:0]      mem_d    [2][DEPTH];
  logic [PW-1:0]   wr_ptr_q [2];
  logic [PW-1:0]   wr_ptr_d [2];
  logic [PW-1:0]   rd_ptr_q [2];
  logic [PW-1:0]   rd_ptr_d [2];
  logic [LVLW-1:0] level_q  [2];
  logic [LVLW-1:0] level_d  [2];
  logic [7:0]      hold_q   [2];
  logic [7:0]      hold_d   [2];
  logic [7:0]      head     [2];
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      out_ready;
  logic            in_ready;
  logic            accept;
  logic            par_ok;

  assign out_ready = {bus.out2_ready, bus.out1_ready};
  // Ready depends only on the addressed channel's fullness, never on in_valid.
  assign in_ready  = (level_q[bus.in_sel] != FULL_LVL);
  assign accept    = bus.in_valid && in_ready;

`ifdef EIGHT_BIT_DEMUX_PARITY_EN
  logic [7:0] err_q;
  logic [7:0] err_d;

  assign par_ok = ~^{bus.in_data, bus.in_parity};

  always_comb begin
    err_d = err_q;
    if (accept && !par_ok && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 8'h00;
    else          err_q <= err_d;
  end

  assign bus.err_count = err_q;
`else
  logic unused_parity;

  assign par_ok        = 1'b1;
  assign unused_parity = bus.in_parity;
  assign bus.err_count = 8'h00;
`endif

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    push     = '0;
    pop      = '0;
    for (int c = 0; c < 2; c++) begin
      push[c] = accept && (bus.in_sel == 1'(c)) && par_ok;
      pop[c]  = (level_q[c] != '0) && out_ready[c];
      head[c] = (level_q[c] != '0) ? mem_q[c][rd_ptr_q[c]] : hold_q[c];
      hold_d[c] = head[c];
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = bus.in_data;
        wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      end
      if (pop[c]) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      if (push[c] && !pop[c])      level_d[c] = level_q[c] + 1'b1;
      else if (pop[c] && !push[c]) level_d[c] = level_q[c] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        level_q[c]  <= '0;
        hold_q[c]   <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  // Storage needs no reset: the head mux shows hold_q until an entry is written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out1_data  = head[0];
  assign bus.out2_data  = head[1];
  assign bus.out1_valid = (level_q[0] != '0);
  assign bus.out2_valid = (level_q[1] != '0);
  assign bus.ch1_level  = level_q[0];
  assign bus.ch2_level  = level_q[1];
endmodule

// File: tb/tb_eight_bit_demux_fifo.sv
// tb/tb_eight_bit_demux_fifo.sv - directed self-checking bench for eight_bit_demux_fifo
module tb_eight_bit_demux_fifo;
  localparam int DEPTH = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  eight_bit_demux_fifo_if #(.DEPTH(DEPTH)) bus_if ();

  eight_bit_demux_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] d, input logic par);
    bus_if.in_valid  = v;
    bus_if.in_sel    = sel;
    bus_if.in_data   = d;
    bus_if.in_parity = par;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    bus_if.out1_ready = 1'b0;
    bus_if.out2_ready = 1'b0;
    #12;
    check("rst_lvl1", 32'(bus_if.ch1_level), 0);
    check("rst_lvl2", 32'(bus_if.ch2_level), 0);
    check("rst_v1", 32'(bus_if.out1_valid), 0);
    check("rst_d2", 32'(bus_if.out2_data), 0);
    check("rst_rdy", 32'(bus_if.in_ready), 1);
    check("rst_err", 32'(bus_if.err_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // alternating channels, consumers ready
    bus_if.out1_ready = 1'b1;
    bus_if.out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h11, 1'b0);
    step();
    check("alt_v1", 32'(bus_if.out1_valid), 1);
    check("alt_d1a", 32'(bus_if.out1_data), 32'h11);
    drive(1'b1, 1'b1, 8'h22, 1'b0);
    step();
    check("alt_v1_pop", 32'(bus_if.out1_valid), 0);
    check("alt_d2a", 32'(bus_if.out2_data), 32'h22);
    drive(1'b1, 1'b0, 8'h33, 1'b0);
    step();
    check("alt_d1b", 32'(bus_if.out1_data), 32'h33);
    check("alt_v2_pop", 32'(bus_if.out2_valid), 0);
    drive(1'b1, 1'b1, 8'h44, 1'b0);
    step();
    check("alt_d2b", 32'(bus_if.out2_data), 32'h44);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("alt_empty1", 32'(bus_if.ch1_level), 0);
    check("alt_empty2", 32'(bus_if.ch2_level), 0);

    // fill channel 1 past DEPTH
    bus_if.out1_ready = 1'b0;
    bus_if.out2_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
      #1;
      check("full_rdy", 32'(bus_if.in_ready), (i < 4) ? 1 : 0);
      step();
    end
    check("full_lvl", 32'(bus_if.ch1_level), 4);
    check("full_head", 32'(bus_if.out1_data), 32'hA0);
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    #1;
    check("ch2_indep_rdy", 32'(bus_if.in_ready), 1);
    step();
    check("ch2_indep_lvl", 32'(bus_if.ch2_level), 1);
    check("ch2_indep_d", 32'(bus_if.out2_data), 32'h55);

    // one pop from full, then refill to exercise wrap
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    bus_if.out1_ready = 1'b1;
    step();
    bus_if.out1_ready = 1'b0;
    check("pop_lvl", 32'(bus_if.ch1_level), 3);
    check("pop_rdy", 32'(bus_if.in_ready), 1);
    drive(1'b1, 1'b0, 8'hA4, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("wrap_lvl", 32'(bus_if.ch1_level), 4);
    bus_if.out1_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("wrap_order", 32'(bus_if.out1_data), 32'hA0 + 32'(i));
      step();
    end
    bus_if.out1_ready = 1'b0;
    check("wrap_drained", 32'(bus_if.out1_valid), 0);

    // drain ch2, preload two, then push+pop together
    bus_if.out2_ready = 1'b1;
    step();
    bus_if.out2_ready = 1'b0;
    check("ch2_drained", 32'(bus_if.ch2_level), 0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'hB0 + 8'(i), 1'b0);
      exp_q.push_back(8'hB0 + 8'(i));
      step();
    end
    check("sim_pre_lvl", 32'(bus_if.ch2_level), 2);
    bus_if.out2_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'hB0 + 8'(i), 1'b0);
      exp_q.push_back(8'hB0 + 8'(i));
      check("sim_head", 32'(bus_if.out2_data), 32'(exp_q.pop_front()));
      step();
      check("sim_lvl", 32'(bus_if.ch2_level), 2);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    bus_if.out2_ready = 1'b0;
    check("sim_tail", 32'(bus_if.out2_data), 32'hB6);

    // async reset with both channels holding data
    bus_if.out2_ready = 1'b1;
    step();
    step();
    bus_if.out2_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
      step();
      drive(1'b1, 1'b1, 8'hD0 + 8'(i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("pre_rst_lvl1", 32'(bus_if.ch1_level), 3);
    check("pre_rst_lvl2", 32'(bus_if.ch2_level), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_lvl1", 32'(bus_if.ch1_level), 0);
    check("arst_lvl2", 32'(bus_if.ch2_level), 0);
    check("arst_v1", 32'(bus_if.out1_valid), 0);
    check("arst_v2", 32'(bus_if.out2_valid), 0);
    check("arst_d1", 32'(bus_if.out1_data), 0);
    check("arst_d2", 32'(bus_if.out2_data), 0);
    check("arst_rdy", 32'(bus_if.in_ready), 1);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_v1", 32'(bus_if.out1_valid), 0);
    check("post_rst_v2", 32'(bus_if.out2_valid), 0);

    // parity handling
    bus_if.out1_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h03, 1'b1);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef EIGHT_BIT_DEMUX_PARITY_EN
    check("par_drop_lvl", 32'(bus_if.ch1_level), 0);
    check("par_err1", 32'(bus_if.err_count), 1);
    drive(1'b1, 1'b0, 8'h03, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("par_good_lvl", 32'(bus_if.ch1_level), 1);
    check("par_good_d", 32'(bus_if.out1_data), 32'h03);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 8'h01, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("par_sat", 32'(bus_if.err_count), 32'hFF);
    check("par_sat_lvl2", 32'(bus_if.ch2_level), 0);
`else
    check("nopar_lvl", 32'(bus_if.ch1_level), 1);
    check("nopar_d", 32'(bus_if.out1_data), 32'h03);
    check("nopar_err", 32'(bus_if.err_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
